key_input_unit: RTL and testbench

//  Parametrised push-switch front end for the debugger's hex keypad entry.
//  - 2-FF synchronises NKEYS digit keys plus CLEAR and BACKSPACE switches.
//  - Debounces each input with a per-input stability counter.
//  - Encodes single key presses to a hex value and shifts it into a DIGITS-nibble entry buffer.
//  - Output feeds the debugger's input_val and the 7SEG decoders.

---
 rtl/key_input_unit.sv | 138 +++++++++++++
 tb/tb_key_input_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_unit.sv
// key_input_unit: push-switch front end for the debugger's hex keypad.
// Synchronises and debounces the digit keys plus CLEAR and BACKSPACE,
// turns single debounced presses into hex digits and shifts them into an
// entry buffer that feeds input_val and the seven-segment decoders.

module key_input_unit #(
    parameter int NKEYS    = 16,
    parameter int DIGITS   = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NKEYS-1:0]            keys_raw,
    input  logic                        clear_raw,
    input  logic                        bksp_raw,
    output logic [4*DIGITS-1:0]         out,
    output logic [$clog2(DIGITS+1)-1:0] count,
    output logic                        key_strobe,
    output logic [3:0]                  key_val,
    output logic                        overflow,
    output logic                        conflict
);

    localparam int NIN      = NKEYS + 2;
    localparam int CLR_IDX  = NKEYS;
    localparam int BKSP_IDX = NKEYS + 1;
    localparam int CW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int OW       = 4 * DIGITS;
    localparam int CNTW     = $clog2(DIGITS + 1);

    logic [NIN-1:0]    raw_all;
    logic [NIN-1:0]    sync1;
    logic [NIN-1:0]    sync2;
    logic [NIN-1:0]    db;
    logic [NIN-1:0]    db_prev;
    logic [CW-1:0]     stable_cnt [NIN];
    logic [NIN-1:0]    press;
    logic [NKEYS-1:0]  digit_press;
    logic              clear_ev;
    logic              bksp_ev;
    logic [4:0]        n_press;
    logic [3:0]        digit_idx;

    // Digit keys occupy the low bits; CLEAR and BACKSPACE sit just above them.
    assign raw_all = {bksp_raw, clear_raw, keys_raw};

    // Two-flop synchroniser for every switch input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_all;
            sync2 <= sync1;
        end
    end

    // Per-input debounce: the level only flips after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db      <= '0;
            db_prev <= '0;
            for (int n = 0; n < NIN; n++) begin
                stable_cnt[n] <= '0;
            end
        end else begin
            db_prev <= db;
            for (int n = 0; n < NIN; n++) begin
                if (sync2[n] != db[n]) begin
                    if (stable_cnt[n] == CW'(DEBOUNCE - 1)) begin
                        db[n]         <= ~db[n];
                        stable_cnt[n] <= '0;
                    end else begin
                        stable_cnt[n] <= stable_cnt[n] + CW'(1);
                    end
                end else begin
                    stable_cnt[n] <= '0;
                end
            end
        end
    end

    // Only rising debounced levels count as events; releases are ignored.
    assign press       = db & ~db_prev;
    assign digit_press = press[NKEYS-1:0];
    assign clear_ev    = press[CLR_IDX];
    assign bksp_ev     = press[BKSP_IDX];

    // Count simultaneous digit presses and encode the pressed key index.
    always_comb begin
        n_press   = '0;
        digit_idx = '0;
        for (int k = 0; k < NKEYS; k++) begin
            if (digit_press[k]) begin
                n_press   = n_press + 5'd1;
                digit_idx = 4'(k);
            end
        end
    end

    // Entry buffer update with CLEAR over BACKSPACE over digit priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out        <= '0;
            count      <= '0;
            key_strobe <= 1'b0;
            key_val    <= '0;
            overflow   <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            conflict   <= 1'b0;
            if (clear_ev) begin
                out      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (bksp_ev) begin
                out      <= out >> 4;
                overflow <= 1'b0;
                if (count != '0) begin
                    count <= count - CNTW'(1);
                end
            end else if (n_press == 5'd1) begin
                out        <= (out << 4) | OW'(digit_idx);
                key_val    <= digit_idx;
                key_strobe <= 1'b1;
                if (count == CNTW'(DIGITS)) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNTW'(1);
                end
            end else if (n_press > 5'd1) begin
                conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_input_unit.sv
// tb_key_input_unit: randomized and directed stimulus for key_input_unit,
// checked against a digit-list reference model and an event scoreboard.

module tb_key_input_unit;

    localparam int NKEYS    = 16;
    localparam int DIGITS   = 8;
    localparam int DEBOUNCE = 4;
    localparam int NIN      = NKEYS + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys_raw = '0;
    logic        clear_raw = 1'b0;
    logic        bksp_raw = 1'b0;
    logic [31:0] out;
    logic [3:0]  count;
    logic        key_strobe;
    logic [3:0]  key_val;
    logic        overflow;
    logic        conflict;

    key_input_unit #(
        .NKEYS    (NKEYS),
        .DIGITS   (DIGITS),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .keys_raw   (keys_raw),
        .clear_raw  (clear_raw),
        .bksp_raw   (bksp_raw),
        .out        (out),
        .count      (count),
        .key_strobe (key_strobe),
        .key_val    (key_val),
        .overflow   (overflow),
        .conflict   (conflict)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state: entry is a list of digits, most recent first.
    typedef struct {
        bit          is_conflict;
        logic [3:0]  val;
        logic [31:0] bufv;
        int          cnt;
        bit          ovf;
    } ev_t;

    logic [NIN-1:0] rawq [$];
    bit             mdb [NIN];
    int             run_len [NIN];
    logic [NIN-1:0] pend = '0;
    int             digs [$];
    ev_t            sb [$];
    logic [31:0]    exp_out = '0;
    int             exp_count = 0;
    bit             exp_ovf = 0;
    bit             exp_strobe = 0;
    bit             exp_conflict = 0;
    logic [3:0]     exp_keyval = '0;

    function automatic logic [31:0] packDigits();
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < digs.size(); k++) begin
            r = r | (32'(digs[k]) << (4 * k));
        end
        return r;
    endfunction

    // Model: raw samples reach the debouncer two edges late; a level flips once
    // DEBOUNCE successive samples disagree; a rising flip acts on the next edge.
    always @(posedge clock) begin : model_proc
        logic [NIN-1:0] seen;
        int             presses;
        int             idx;
        ev_t            ev;
        if (reset) begin
            rawq.delete();
            rawq.push_back('0);
            rawq.push_back('0);
            for (int n = 0; n < NIN; n++) begin
                mdb[n]     = 0;
                run_len[n] = 0;
            end
            pend = '0;
            digs.delete();
            exp_out      = '0;
            exp_count    = 0;
            exp_ovf      = 0;
            exp_strobe   = 0;
            exp_conflict = 0;
            exp_keyval   = '0;
        end else begin
            exp_strobe   = 0;
            exp_conflict = 0;
            if (pend[NKEYS]) begin
                digs.delete();
                exp_ovf = 0;
            end else if (pend[NKEYS+1]) begin
                if (digs.size() > 0) void'(digs.pop_front());
                exp_ovf = 0;
            end else begin
                presses = 0;
                idx     = 0;
                for (int k = 0; k < NKEYS; k++) begin
                    if (pend[k]) begin
                        presses++;
                        idx = k;
                    end
                end
                if (presses == 1) begin
                    digs.push_front(idx);
                    if (digs.size() > DIGITS) begin
                        void'(digs.pop_back());
                        exp_ovf = 1;
                    end
                    exp_keyval = 4'(idx);
                    exp_strobe = 1;
                end else if (presses > 1) begin
                    exp_conflict = 1;
                end
            end
            exp_out   = packDigits();
            exp_count = digs.size();
            if (exp_strobe || exp_conflict) begin
                ev.is_conflict = exp_conflict;
                ev.val         = exp_keyval;
                ev.bufv        = exp_out;
                ev.cnt         = exp_count;
                ev.ovf         = exp_ovf;
                sb.push_back(ev);
            end
            pend = '0;
            rawq.push_back({bksp_raw, clear_raw, keys_raw});
            seen = rawq.pop_front();
            for (int n = 0; n < NIN; n++) begin
                if (seen[n] != mdb[n]) begin
                    run_len[n]++;
                    if (run_len[n] == DEBOUNCE) begin
                        mdb[n]     = ~mdb[n];
                        run_len[n] = 0;
                        if (mdb[n]) pend[n] = 1'b1;
                    end
                end else begin
                    run_len[n] = 0;
                end
            end
        end
    end

    // Monitor: compares outputs each cycle and pops the scoreboard on every strobe or conflict.
    always @(negedge clock) begin : monitor_proc
        ev_t ev;
        checkOutput("out", out, exp_out);
        checkOutput("count", 32'(count), 32'(exp_count));
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        checkOutput("key_val", 32'(key_val), 32'(exp_keyval));
        checkOutput("key_strobe", 32'(key_strobe), 32'(exp_strobe));
        checkOutput("conflict", 32'(conflict), 32'(exp_conflict));
        if (key_strobe || conflict) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL sb_unexpected: got strobe=%0b conflict=%0b, expected no event at %0t",
                         key_strobe, conflict, $time);
            end else begin
                ev = sb.pop_front();
                checkOutput("sb_kind", 32'(conflict), 32'(ev.is_conflict));
                if (key_strobe) checkOutput("sb_val", 32'(key_val), 32'(ev.val));
                checkOutput("sb_out", out, ev.bufv);
                checkOutput("sb_count", 32'(count), 32'(ev.cnt));
                checkOutput("sb_ovf", 32'(overflow), 32'(ev.ovf));
            end
        end
    end

    bit strobe_seen;
    bit conflict_seen;

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clock);
            if (key_strobe) strobe_seen = 1;
            if (conflict) conflict_seen = 1;
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, input logic c, input logic b, input int hold, input int rel);
        keys_raw  = k;
        clear_raw = c;
        bksp_raw  = b;
        runCycles(hold);
        keys_raw  = '0;
        clear_raw = 1'b0;
        bksp_raw  = 1'b0;
        runCycles(rel);
    endtask

    task automatic pressKey(input int i);
        applyStimulus(16'd1 << i, 1'b0, 1'b0, DEBOUNCE + 4, DEBOUNCE + 4);
    endtask

    task automatic measureLatency(output int edges);
        edges = 0;
        while (edges < 20) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (key_strobe) break;
        end
        #1;
    endtask

    // Safety net so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int lat;
        int op;
        int a;
        int b;
        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("reset_out", out, 32'h0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        #1;
        reset = 1'b0;
        runCycles(2);

        // Single held key: strobe on the 7th edge after the rise
        keys_raw = 16'd1 << 5;
        measureLatency(lat);
        checkOutput("t1_latency", 32'(lat), 32'd7);
        checkOutput("t1_out", out, 32'h5);
        checkOutput("t1_count", 32'(count), 32'd1);
        checkOutput("t1_key_val", 32'(key_val), 32'd5);
        keys_raw = '0;
        runCycles(10);

        // Nine digits into an eight-digit buffer
        applyStimulus('0, 1'b1, 1'b0, DEBOUNCE + 2, DEBOUNCE + 4);
        for (int i = 1; i <= 9; i++) pressKey(i);
        checkOutput("t2_out", out, 32'h23456789);
        checkOutput("t2_count", 32'(count), 32'd8);
        checkOutput("t2_ovf", 32'(overflow), 32'd1);

        // Glitch shorter than the debounce window
        strobe_seen = 0;
        applyStimulus(16'd1 << 3, 1'b0, 1'b0, DEBOUNCE - 1, 12);
        checkOutput("t3_strobe", 32'(strobe_seen), 32'd0);
        checkOutput("t3_out", out, 32'h23456789);

        // Backspace and clear
        applyStimulus('0, 1'b1, 1'b0, DEBOUNCE + 2, DEBOUNCE + 4);
        checkOutput("t4_clr_ovf", 32'(overflow), 32'd0);
        pressKey(10);
        pressKey(11);
        pressKey(12);
        checkOutput("t4_out", out, 32'hABC);
        checkOutput("t4_count", 32'(count), 32'd3);
        applyStimulus('0, 1'b0, 1'b1, DEBOUNCE + 2, DEBOUNCE + 4);
        checkOutput("t4_bksp_out", out, 32'hAB);
        checkOutput("t4_bksp_count", 32'(count), 32'd2);
        applyStimulus('0, 1'b1, 1'b0, DEBOUNCE + 2, DEBOUNCE + 4);
        checkOutput("t4_clr_out", out, 32'h0);
        checkOutput("t4_clr_count", 32'(count), 32'd0);

        // Simultaneous digits, then CLEAR together with a digit
        pressKey(3);
        strobe_seen   = 0;
        conflict_seen = 0;
        applyStimulus(16'h0006, 1'b0, 1'b0, DEBOUNCE + 4, DEBOUNCE + 4);
        checkOutput("t5_conflict", 32'(conflict_seen), 32'd1);
        checkOutput("t5_no_strobe", 32'(strobe_seen), 32'd0);
        checkOutput("t5_out", out, 32'h3);
        strobe_seen = 0;
        applyStimulus(16'd1 << 7, 1'b1, 1'b0, DEBOUNCE + 4, DEBOUNCE + 4);
        checkOutput("t5_clr_strobe", 32'(strobe_seen), 32'd0);
        checkOutput("t5_clr_out", out, 32'h0);

        // Reset while a key is held
        keys_raw = 16'd1 << 4;
        runCycles(12);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t6_rst_out", out, 32'h0);
        checkOutput("t6_rst_count", 32'(count), 32'd0);
        #1;
        reset = 1'b0;
        measureLatency(lat);
        checkOutput("t6_latency", 32'(lat), 32'd7);
        checkOutput("t6_out", out, 32'h4);
        keys_raw = '0;
        runCycles(10);

        // Randomized key activity
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            a  = $urandom_range(0, NKEYS - 1);
            b  = (a + 1 + $urandom_range(0, NKEYS - 2)) % NKEYS;
            case (op)
                0: applyStimulus('0, 1'b1, 1'b0, $urandom_range(1, 7), $urandom_range(4, 9));
                1: applyStimulus('0, 1'b0, 1'b1, $urandom_range(1, 7), $urandom_range(4, 9));
                2: applyStimulus((16'd1 << a) | (16'd1 << b), 1'b0, 1'b0, $urandom_range(4, 8), 8);
                3: begin
                    keys_raw = 16'd1 << a;
                    runCycles(8);
                    keys_raw = (16'd1 << a) | (16'd1 << b);
                    runCycles(8);
                    keys_raw = '0;
                    runCycles(8);
                end
                default: applyStimulus(16'd1 << a, 1'b0, 1'b0, $urandom_range(1, 8), $urandom_range(1, 8));
            endcase
        end
        runCycles(20);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
